// File: rtl/divider_issue_pkg.sv
// rtl/divider_issue_pkg.sv - shared FSM state type and tag width for the divider issue block
package dividerIssuePkg;

   localparam int TAG_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/divider_issue_fifo.sv
// rtl/divider_issue_fifo.sv - request FIFO holding queued and in-flight divide requests
module divIssueFifo
   import dividerIssuePkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cg,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dividend,
   input  logic [WIDTH-1:0] push_divisor,
   input  logic [TAG_W-1:0] push_tag,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic             multi,
   output logic [WIDTH-1:0] head_dividend,
   output logic [WIDTH-1:0] head_divisor,
   output logic [TAG_W-1:0] head_tag,
   output logic             next_divzero
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] dividend_mem [DEPTH];
   logic [WIDTH-1:0] divisor_mem  [DEPTH];
   logic [TAG_W-1:0] tag_mem      [DEPTH];

   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_next;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   // Full is a pure function of occupancy so the upstream ready never depends on a same-cycle pop
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign multi   = (count > (AW+1)'(1));
   assign do_push = cg && push && !full;
   assign do_pop  = cg && pop && !empty;

   // Pointers wrap for free because DEPTH is a power of two
   assign rd_next = rd_ptr + AW'(1);

   assign head_dividend = dividend_mem[rd_ptr];
   assign head_divisor  = divisor_mem[rd_ptr];
   assign head_tag      = tag_mem[rd_ptr];
   assign next_divzero  = (divisor_mem[rd_next] == '0);

   // Occupancy and pointer bookkeeping; everything holds while the clock gate is low
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_next;
         end
         if (do_push && !do_pop) begin
            count <= count + (AW+1)'(1);
         end else if (do_pop && !do_push) begin
            count <= count - (AW+1)'(1);
         end
      end
   end

   // Entry storage; contents need no reset because occupancy gates every use
   always_ff @(posedge clk) begin
      if (do_push) begin
         dividend_mem[wr_ptr] <= push_dividend;
         divisor_mem[wr_ptr]  <= push_divisor;
         tag_mem[wr_ptr]      <= push_tag;
      end
   end

endmodule

// File: rtl/divider_issue.sv
// rtl/divider_issue.sv - queues divide requests, issues them to an external divider, returns tagged results in order (option: DIVIDER_ISSUE_DIVZERO_BYPASS_EN)
module divider_issue
   import dividerIssuePkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_cg,
   input  logic             i_req_valid,
   output logic             o_req_ready,
   input  logic [WIDTH-1:0] i_req_dividend,
   input  logic [WIDTH-1:0] i_req_divisor,
   input  logic [TAG_W-1:0] i_req_tag,
   output logic             o_div_begin,
   output logic [WIDTH-1:0] o_div_dividend,
   output logic [WIDTH-1:0] o_div_divisor,
   input  logic             i_div_busy,
   input  logic             i_div_done,
   input  logic [WIDTH-1:0] i_div_quotient,
   input  logic [WIDTH-1:0] i_div_remainder,
   output logic             o_rsp_valid,
   input  logic             i_rsp_ready,
   output logic [WIDTH-1:0] o_rsp_quotient,
   output logic [WIDTH-1:0] o_rsp_remainder,
   output logic [TAG_W-1:0] o_rsp_tag,
   output logic             o_rsp_divzero
);

`ifdef DIVIDER_ISSUE_DIVZERO_BYPASS_EN
   localparam logic BYPASS_EN = 1'b1;
`else
   localparam logic BYPASS_EN = 1'b0;
`endif

   state_t           state;
   state_t           state_n;
   logic             full;
   logic             empty;
   logic             multi;
   logic [WIDTH-1:0] head_dividend;
   logic [WIDTH-1:0] head_divisor;
   logic [TAG_W-1:0] head_tag;
   logic             next_divzero;
   logic             head_divzero;
   logic             pop;
   logic             load_div;
   logic             load_byp;
   logic             active;
   logic [WIDTH-1:0] rsp_q;
   logic [WIDTH-1:0] rsp_r;

   divIssueFifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk           (i_clk),
      .rst           (i_rst),
      .cg            (i_cg),
      .push          (i_req_valid),
      .push_dividend (i_req_dividend),
      .push_divisor  (i_req_divisor),
      .push_tag      (i_req_tag),
      .pop           (pop),
      .full          (full),
      .empty         (empty),
      .multi         (multi),
      .head_dividend (head_dividend),
      .head_divisor  (head_divisor),
      .head_tag      (head_tag),
      .next_divzero  (next_divzero)
   );

   assign head_divzero = (head_divisor == '0);
   assign active       = (state != IDLE);

   assign o_req_ready     = !full;
   assign o_div_begin     = (state == ISSUE);
   assign o_div_dividend  = active ? head_dividend : '0;
   assign o_div_divisor   = active ? head_divisor : '0;
   assign o_rsp_valid     = (state == RESP);
   assign o_rsp_quotient  = rsp_q;
   assign o_rsp_remainder = rsp_r;
   assign o_rsp_tag       = o_rsp_valid ? head_tag : '0;
   assign o_rsp_divzero   = o_rsp_valid && head_divzero;

   // State register; reset drops all queued and in-flight work at once
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= IDLE;
      end else if (i_cg) begin
         state <= state_n;
      end
   end

   // Next state, head pop and response-register load strobes
   always_comb begin
      state_n  = state;
      pop      = 1'b0;
      load_div = 1'b0;
      load_byp = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               if (BYPASS_EN && head_divzero) begin
                  state_n  = RESP;
                  load_byp = 1'b1;
               end else if (!i_div_busy) begin
                  state_n = ISSUE;
               end
            end
         end
         ISSUE: begin
            state_n = WAIT;
         end
         WAIT: begin
            if (i_div_done) begin
               state_n  = RESP;
               load_div = 1'b1;
            end
         end
         RESP: begin
            if (i_rsp_ready) begin
               pop = 1'b1;
               // A zero-divisor successor must take the bypass path from IDLE instead of being issued
               if (multi && !i_div_busy && !(BYPASS_EN && next_divzero)) begin
                  state_n = ISSUE;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Response registers hold the result steady for as long as the consumer stalls
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rsp_q <= '0;
         rsp_r <= '0;
      end else if (i_cg) begin
         if (load_div) begin
            rsp_q <= i_div_quotient;
            rsp_r <= i_div_remainder;
         end else if (load_byp) begin
            rsp_q <= '1;
            rsp_r <= head_dividend;
         end
      end
   end

   // A done pulse outside WAIT is dropped by the FSM; flag it so the integration fault is visible
   assert property (@(posedge i_clk) disable iff (i_rst) (i_cg && i_div_done) |-> (state == WAIT));

endmodule
